xor_cond_invert_stream: RTL and testbench
=========================================

# xor_cond_invert_stream

Parametrised, streaming successor to the combinational XOR/conditional-invert logic. It accepts operand pairs over a valid/ready handshake and produces one registered result per accepted pair. Per beat it selects one of four modes: legacy MSB-invert, parity-invert, chained (output feedback) or LFSR keystream. It sits between the `ui_in`/`uio_in` capture logic and the `uo_out` driver in the top-level tile.

## Interface

- `WIDTH`, 8: operand/result width; legal range 5 and up.
- `SEED`, 1: LFSR reload value, `WIDTH` bits. A value of 0 is replaced by 1.
- `CNT_W`, 16: width of the accepted-word counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `mode`  in  2  per-beat mode, sampled with `in_a`/`in_b` on accept: 0 LEGACY, 1 PARITY, 2 CHAIN, 3 KEYSTREAM.
- `chain_clr`  in  1  clears the chain register and reloads the LFSR with `SEED`.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair.
- `in_a`  in  `WIDTH`  operand A; it also supplies the invert condition.
- `in_b`  in  `WIDTH`  operand B.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_c`  out  `WIDTH`  result.
- `count`  out  `CNT_W`  number of accepted pairs since reset; wraps.

## Operation

- A pair is accepted when `in_valid && in_ready`. The result is accepted downstream when `out_valid && out_ready`.
- Internal state:
  - `prev` (`WIDTH` bits): chain register.
  - `lfsr` (`WIDTH` bits): keystream register.
  - One output register pair: `out_c`, `out_valid`.
- Effective state for the current beat:
  - `p` = `chain_clr` ? 0 : `prev`.
  - `k` = `chain_clr` ? `SEED` : `lfsr`.
- Mode behaviour, with x the pre-invert value and c the result:
  - **LEGACY:** x = a^b; c = a[WIDTH-1] ? ~x : x.
  - **PARITY:** x = a^b; c = (^a) ? ~x : x. Odd parity of A inverts.
  - **CHAIN:** x = a^b^p; c = a[WIDTH-1] ? ~x : x. On accept, `prev` <= c.
  - **KEYSTREAM:** x = a^b^k; c = a[WIDTH-1] ? ~x : x. On accept, `lfsr` <= {k[WIDTH-2:0], fb}, where fb = k[WIDTH-1]^k[WIDTH-3]^k[WIDTH-4]^k[WIDTH-5].
- State update rules:
  - `prev` updates only on CHAIN accepts.
  - `lfsr` advances only on KEYSTREAM accepts.
  - When `chain_clr` is high, `prev` <= 0 and `lfsr` <= `SEED` unless the mode rule above writes them on the same edge; the mode rule wins, computed from cleared values.
  - Changing mode between beats leaves the other mode's state untouched.
- `count` increments by 1 on every accept in any mode. It wraps from all-ones to 0.
- Reset values (`rst_n` low at an edge): `out_valid`=0, `out_c`=0, `count`=0, `prev`=0, `lfsr`=`SEED`. Reset overrides any simultaneous accept. An in-flight result is discarded.

## Timing

- Latency is 1 cycle: a pair accepted at edge N is presented on `out_c` with `out_valid`=1 after edge N.
- `in_ready` = !`out_valid` || `out_ready`. This is combinational from `out_ready`; there is no path from `in_valid` to `in_ready`.
- Throughput is 1 pair/cycle while `out_ready` is held high.
- Simultaneous output drain and new accept: the register loads the new result and `out_valid` stays 1.
- Drain with no new accept: `out_valid` <= 0 and `out_c` holds its last value.
- While `out_valid` && !`out_ready`: `out_c` and `out_valid` are stable, `in_ready`=0, and no state or counter changes.
- `mode` and `chain_clr` have effect only on accepting edges, with the exception that `chain_clr` also clears state on idle edges.

## Test plan

- **LEGACY**, WIDTH=8: a=0x3C, b=0x0F -> `out_c`=0x33 one cycle later. a=0xA5, b=0x0F -> 0x55. `count` reaches 2.
- **PARITY**: a=0x01, b=0x00 -> 0xFE. a=0x03, b=0x00 -> 0x03. a=0x80, b=0x80 -> 0xFF.
- **CHAIN**: pulse `chain_clr`, then feed a=0x10, b=0x01 three times -> 0x11, 0x00, 0x11. Next, assert `chain_clr` together with a fourth identical beat -> 0x11.
- **KEYSTREAM**, SEED=0x01: a=b=0x00 for four beats -> 0x01, 0x02, 0x04, 0x08. Interleaving a LEGACY beat must not advance `lfsr`.
- **Backpressure**: hold `out_ready`=0 and present 0x3C/0x0F then 0x11/0x22 -> `out_c`=0x33 stable, `in_ready`=0, `count`=1. Release `out_ready` -> second result 0x33 appears the next cycle and `count`=2.
- **Reset and wrap**: with `CNT_W`=4, accept 16 beats -> `count` wraps to 0. Assert `rst_n`=0 while `out_valid`=1 -> after the edge, `out_valid`=0, `count`=0, and the first CHAIN beat uses `prev`=0.

Source files
------------

// File: rtl/xor_cond_invert_stream.sv
// Streaming XOR / conditional-invert unit with four per-beat modes (legacy, parity,
// chained feedback, LFSR keystream) behind a valid/ready handshake, one registered stage.
module xor_cond_invert_stream #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   SEED  = WIDTH'(1),
  parameter int                 CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             chain_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [CNT_W-1:0] count
);

  localparam logic [1:0] MODE_LEGACY    = 2'd0;
  localparam logic [1:0] MODE_PARITY    = 2'd1;
  localparam logic [1:0] MODE_CHAIN     = 2'd2;
  localparam logic [1:0] MODE_KEYSTREAM = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  function automatic logic [WIDTH-1:0] cond_invert(input logic [WIDTH-1:0] x,
                                                   input logic             inv);
    return inv ? ~x : x;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] k);
    logic fb;
    fb = k[WIDTH-1] ^ k[WIDTH-3] ^ k[WIDTH-4] ^ k[WIDTH-5];
    return {k[WIDTH-2:0], fb};
  endfunction

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] res_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic             accept;
  logic [WIDTH-1:0] p_eff;
  logic [WIDTH-1:0] k_eff;
  logic [WIDTH-1:0] x_p0;
  logic             inv_p0;
  logic [WIDTH-1:0] c_p0;

  assign in_ready  = !vld_p1 || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p1;
  assign out_c     = res_p1;
  assign count     = cnt_p1;

  // Stage p0: combinational result from the operands and the effective (possibly cleared) state.
  always_comb begin
    p_eff  = chain_clr ? '0 : prev;
    k_eff  = chain_clr ? SEED_EFF : lfsr;
    x_p0   = in_a ^ in_b;
    inv_p0 = in_a[WIDTH-1];
    case (mode)
      MODE_PARITY:    inv_p0 = ^in_a;
      MODE_CHAIN:     x_p0   = in_a ^ in_b ^ p_eff;
      MODE_KEYSTREAM: x_p0   = in_a ^ in_b ^ k_eff;
      default:        x_p0   = in_a ^ in_b;
    endcase
    c_p0 = cond_invert(x_p0, inv_p0);
  end

  // Stage p1: output register, counter and mode state. A stalled output freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      cnt_p1 <= '0;
      prev   <= '0;
      lfsr   <= SEED_EFF;
    end else begin
      if (accept) begin
        res_p1 <= c_p0;
        vld_p1 <= 1'b1;
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end

      if (accept && mode == MODE_CHAIN) begin
        prev <= c_p0;
      end else if (in_ready && chain_clr) begin
        prev <= '0;
      end

      if (accept && mode == MODE_KEYSTREAM) begin
        lfsr <= lfsr_step(k_eff);
      end else if (in_ready && chain_clr) begin
        lfsr <= SEED_EFF;
      end
    end
  end

endmodule

// File: tb/tb_xor_cond_invert_stream.sv
// Directed, table-driven bench for xor_cond_invert_stream (WIDTH=8, SEED=1, CNT_W=4).
module tb_xor_cond_invert_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       chain_clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c;
  logic [3:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  xor_cond_invert_stream #(.WIDTH(8), .SEED(8'h01), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .chain_clr(chain_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .count(count)
  );

  typedef struct {
    logic       acc;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic clr, input logic [1:0] m,
                       input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid  = v;
    chain_clr = clr;
    mode      = m;
    in_a      = a;
    in_b      = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    chain_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; chain_clr = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;

    // acc clr mode  a      b      expected out_c
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h3C, 8'h0F, 8'h33};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'hA5, 8'h0F, 8'h55};
    tbl[2]  = '{1'b1, 1'b0, 2'd1, 8'h01, 8'h00, 8'hFE};
    tbl[3]  = '{1'b1, 1'b0, 2'd1, 8'h03, 8'h00, 8'h03};
    tbl[4]  = '{1'b1, 1'b0, 2'd1, 8'h80, 8'h80, 8'hFF};
    tbl[5]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'hFF};
    tbl[6]  = '{1'b1, 1'b0, 2'd2, 8'h10, 8'h01, 8'h11};
    tbl[7]  = '{1'b1, 1'b0, 2'd2, 8'h10, 8'h01, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 2'd2, 8'h10, 8'h01, 8'h11};
    tbl[9]  = '{1'b1, 1'b1, 2'd2, 8'h10, 8'h01, 8'h11};
    tbl[10] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 8'h01};
    tbl[11] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 8'h02};
    tbl[12] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 8'h04};
    tbl[13] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 8'h08};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00};
    tbl[15] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 8'h11};
    tbl[16] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 8'h23};
    tbl[17] = '{1'b1, 1'b0, 2'd1, 8'hF0, 8'h0F, 8'hFF};

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 16'(out_valid), 16'd0);
    check("reset out_c", 16'(out_c), 16'h00);
    check("reset count", 16'(count), 16'd0);
    check("reset in_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 17 accepts from reset: count passes 15 and wraps to 1 at the last entry.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].acc, tbl[i].clr, tbl[i].mode, tbl[i].a, tbl[i].b);
      if (tbl[i].acc) exp_cnt = (exp_cnt + 1) % 16;
      check($sformatf("vec%0d out_c", i), 16'(out_c), 16'(tbl[i].c));
      check($sformatf("vec%0d out_valid", i), 16'(out_valid), 16'(tbl[i].acc));
      check($sformatf("vec%0d count", i), 16'(count), 16'(exp_cnt));
    end
    check("wrap count", 16'(count), 16'd1);

    // Backpressure: drain, then stall with the output register full.
    drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    check("drain out_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 8'h3C, 8'h0F);
    check("bp first out_c", 16'(out_c), 16'h33);
    check("bp count1", 16'(count), 16'd2);
    @(negedge clk);
    in_valid = 1'b1; mode = 2'd0; in_a = 8'h11; in_b = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp stall%0d out_c", i), 16'(out_c), 16'h33);
      check($sformatf("bp stall%0d in_ready", i), 16'(in_ready), 16'd0);
      check($sformatf("bp stall%0d count", i), 16'(count), 16'd2);
      check($sformatf("bp stall%0d out_valid", i), 16'(out_valid), 16'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp release out_c", 16'(out_c), 16'h33);
    check("bp release count", 16'(count), 16'd3);
    check("bp release out_valid", 16'(out_valid), 16'd1);

    // Reset while a result is in flight and a new beat is offered; prev currently holds 0x11.
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; mode = 2'd2; in_a = 8'h10; in_b = 8'h01;
    @(posedge clk);
    #1;
    check("rst out_valid", 16'(out_valid), 16'd0);
    check("rst count", 16'(count), 16'd0);
    check("rst out_c", 16'(out_c), 16'h00);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    drive(1'b1, 1'b0, 2'd2, 8'h10, 8'h01);
    check("post-rst chain out_c", 16'(out_c), 16'h11);
    drive(1'b1, 1'b0, 2'd3, 8'h00, 8'h00);
    check("post-rst keystream out_c", 16'(out_c), 16'h01);
    check("post-rst count", 16'(count), 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
